// File: rtl/posit_defines_es3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_defines_es3 : widths, constants and value layout for 32-bit es=3    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package posit_defines_es3;

  localparam int NBITS                      = 32;
  localparam int ES                         = 3;
  localparam int POSIT_SERIALIZED_WIDTH_ES3 = 38;
  localparam int SCALE_W                    = 9;
  localparam int FRAC_W                     = NBITS - ES - 3;
  localparam int SHIFT_W                    = $clog2(NBITS);

  localparam int               POSIT_MAX_SCALE_ES3 = 240;
  localparam logic [NBITS-1:0] POSIT_MAXPOS_ES3    = 32'h7FFF_FFFF;
  localparam logic [NBITS-1:0] POSIT_MINPOS_ES3    = 32'h0000_0001;
  localparam logic [NBITS-1:0] POSIT_NAR_ES3       = 32'h8000_0000;

  typedef struct packed {
    logic                      sgn;
    logic signed [SCALE_W-1:0] scale;
    logic [FRAC_W-1:0]         fraction;
    logic                      inf;
    logic                      zero;
  } value_t;

  function automatic logic [NBITS-1:0] posit_apply_sign(input logic sgn,
                                                        input logic [NBITS-1:0] mag);
    return sgn ? ((~mag) + NBITS'(1)) : mag;
  endfunction

endpackage
`default_nettype wire

// File: rtl/posit_shift_right_sticky.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_shift_right_sticky : logical right shift, OR of shifted-out bits    |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module posit_shift_right_sticky #(
  parameter int N = 32,
  parameter int S = 5
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c,
  output logic         sticky
);

  logic [N-1:0] w_lost_mask;

  assign c           = a >> b;
  assign w_lost_mask = ~({N{1'b1}} << b);
  assign sticky      = |(a & w_lost_mask);

endmodule
`default_nettype wire

// File: rtl/posit_normalize_pipe_es3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | posit_normalize_pipe_es3 : 3-stage serialized-value to 32-bit posit pack  |
// | Option POSIT_NORMALIZE_RNE_EN selects round-to-nearest-even (else trunc)  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module posit_normalize_pipe_es3
  import posit_defines_es3::*;
(
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [POSIT_SERIALIZED_WIDTH_ES3-1:0] in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NBITS-1:0]                      out_posit
);

  localparam logic signed [SCALE_W-1:0] c_scale_max = SCALE_W'(POSIT_MAX_SCALE_ES3);
  localparam logic signed [SCALE_W-1:0] c_scale_min = -c_scale_max;

  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  // ---------------- stage 1: clamp and split scale ----------------
  value_t                    w_in;
  logic                      w_ovf;
  logic                      w_unf;
  logic signed [SCALE_W-1:0] w_scale_c;
  logic                      w_kneg;
  logic [SHIFT_W-1:0]        w_kmag;
  logic [SHIFT_W-1:0]        w_fill_len;

  assign w_in  = in_data;
  assign w_ovf = w_in.scale > c_scale_max;
  assign w_unf = w_in.scale < c_scale_min;

  always_comb begin
    w_scale_c = w_in.scale;
    if (w_ovf) begin
      w_scale_c = c_scale_max;
    end else if (w_unf) begin
      w_scale_c = c_scale_min;
    end
  end

  // Fill run before the regime terminator: k+1 ones for k>=0, -k zeros for k<0.
  assign w_kneg     = w_scale_c[SCALE_W-1];
  assign w_kmag     = w_scale_c[SCALE_W-2:ES];
  assign w_fill_len = w_kneg ? ((~w_kmag) + SHIFT_W'(1)) : (w_kmag + SHIFT_W'(1));

  logic               r1_valid;
  logic               r1_sgn;
  logic               r1_inf;
  logic               r1_zero;
  logic               r1_ovf;
  logic               r1_unf;
  logic               r1_kneg;
  logic [SHIFT_W-1:0] r1_fill_len;
  logic [ES-1:0]      r1_exp;
  logic [FRAC_W-1:0]  r1_frac;

  // ---------------- stage 2: regime shift, guard and sticky ----------------
  logic [NBITS-1:0] w_shift_in;
  logic [NBITS-1:0] w_shifted;
  logic             w_shift_sticky;
  logic [NBITS-1:0] w_regime_mask;
  logic [NBITS-1:0] w_body;

  assign w_shift_in = {r1_kneg, r1_exp, r1_frac, 2'b00};

  posit_shift_right_sticky #(
    .N (NBITS),
    .S (SHIFT_W)
  ) u_regime_shift (
    .a      (w_shift_in),
    .b      (r1_fill_len),
    .c      (w_shifted),
    .sticky (w_shift_sticky)
  );

  assign w_regime_mask = r1_kneg ? '0 : ~({NBITS{1'b1}} >> r1_fill_len);
  assign w_body        = w_shifted | w_regime_mask;

  logic             r2_valid;
  logic             r2_sgn;
  logic             r2_inf;
  logic             r2_zero;
  logic             r2_ovf;
  logic             r2_unf;
  logic [NBITS-2:0] r2_kept;
  logic             r2_guard;
  logic             r2_sticky;

  // ---------------- stage 3: round, clamp, sign ----------------
  logic             w_round;
  logic [NBITS-1:0] w_sum;
  logic [NBITS-1:0] w_mag;
  logic [NBITS-1:0] w_posit;

`ifdef POSIT_NORMALIZE_RNE_EN
  assign w_round = r2_guard & (r2_kept[0] | r2_sticky);
`else
  logic w_unused_round;
  assign w_round        = 1'b0;
  assign w_unused_round = r2_guard | r2_sticky;
`endif

  assign w_sum = {1'b0, r2_kept} + NBITS'(w_round);

  always_comb begin
    w_mag = w_sum;
    if (w_sum[NBITS-1] | r2_ovf) begin
      w_mag = POSIT_MAXPOS_ES3;
    end else if ((w_sum == '0) | r2_unf) begin
      w_mag = POSIT_MINPOS_ES3;
    end
    w_posit = posit_apply_sign(r2_sgn, w_mag);
    if (r2_inf) begin
      w_posit = POSIT_NAR_ES3;
    end else if (r2_zero) begin
      w_posit = '0;
    end
  end

  logic             r3_valid;
  logic [NBITS-1:0] r3_posit;

  assign out_valid = r3_valid;
  assign out_posit = r3_posit;

  // All stages advance together so a stall freezes the whole pipe in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_valid    <= 1'b0;
      r1_sgn      <= 1'b0;
      r1_inf      <= 1'b0;
      r1_zero     <= 1'b0;
      r1_ovf      <= 1'b0;
      r1_unf      <= 1'b0;
      r1_kneg     <= 1'b0;
      r1_fill_len <= '0;
      r1_exp      <= '0;
      r1_frac     <= '0;
      r2_valid    <= 1'b0;
      r2_sgn      <= 1'b0;
      r2_inf      <= 1'b0;
      r2_zero     <= 1'b0;
      r2_ovf      <= 1'b0;
      r2_unf      <= 1'b0;
      r2_kept     <= '0;
      r2_guard    <= 1'b0;
      r2_sticky   <= 1'b0;
      r3_valid    <= 1'b0;
      r3_posit    <= '0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_sgn      <= w_in.sgn;
      r1_inf      <= w_in.inf;
      r1_zero     <= w_in.zero;
      r1_ovf      <= w_ovf;
      r1_unf      <= w_unf;
      r1_kneg     <= w_kneg;
      r1_fill_len <= w_fill_len;
      r1_exp      <= w_scale_c[ES-1:0];
      r1_frac     <= w_in.fraction;

      r2_valid    <= r1_valid;
      r2_sgn      <= r1_sgn;
      r2_inf      <= r1_inf;
      r2_zero     <= r1_zero;
      r2_ovf      <= r1_ovf;
      r2_unf      <= r1_unf;
      r2_kept     <= w_body[NBITS-1:1];
      r2_guard    <= w_body[0];
      r2_sticky   <= w_shift_sticky;

      r3_valid    <= r2_valid;
      r3_posit    <= w_posit;
    end
  end

endmodule
`default_nettype wire
